// File: rtl/mul_div_unit.sv
// Iterative 32-bit MIPS32 multiply/divide unit: MULTU/MULT/DIVU/DIV in a fixed 33 cycles.
// Shift-add multiply and restoring divide on operand magnitudes, sign fix-up in the final cycle.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   count_q;
    logic            is_div_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic [W-1:0]    a_raw_q;
    logic [W-1:0]    addend_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    rem_q;

    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_d;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W-1:0]    div_rem_d;
    logic [W-1:0]    div_quo_d;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    // Operand magnitudes; 0x80000000 negates to itself, which is the right magnitude.
    always_comb begin
        a_mag = (op[0] && a[W-1]) ? W'(-a) : a;
        b_mag = (op[0] && b[W-1]) ? W'(-b) : b;
    end

    // One iteration of each datapath; acc_q[31:0] holds the multiplier or the shifting dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, addend_q} : (W+1)'(0));
        mul_d     = {mul_sum, acc_q[W-1:1]};
        div_shift = {rem_q, acc_q[W-1]};
        div_ge    = (div_shift >= {1'b0, addend_q});
        div_rem_d = div_ge ? W'(div_shift - {1'b0, addend_q}) : div_shift[W-1:0];
        div_quo_d = {acc_q[W-2:0], div_ge};
    end

    always_comb begin
        prod_fix = neg_res_q ? (2*W)'(-acc_q) : acc_q;
        quo_fix  = neg_res_q ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? W'(-rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            a_raw_q     <= '0;
            addend_q    <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q    <= op[1];
                        neg_res_q   <= op[0] & (a[W-1] ^ b[W-1]);
                        neg_rem_q   <= op[0] & a[W-1];
                        a_raw_q     <= a;
                        addend_q    <= op[1] ? b_mag : a_mag;
                        acc_q       <= {(W)'(0), op[1] ? a_mag : b_mag};
                        rem_q       <= '0;
                        count_q     <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (is_div_q) begin
                        acc_q <= {acc_q[2*W-1:W], div_quo_d};
                        rem_q <= div_rem_d;
                    end else begin
                        acc_q <= mul_d;
                    end
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(W-1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    if (!is_div_q) begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end else if (addend_q == '0) begin
                        hi          <= a_raw_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    count_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: hand-computed products, quotients and handshake timing.
module tb_mul_div_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_tests;
    int n_fail;
    int cyc;
    int acc_cyc;
    int busy_cnt;
    int done_cnt;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive a start for one edge; on return we sit just after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start   = 1'b0;
        a       = 32'hDEAD_BEEF;
        b       = 32'h1234_5678;
        acc_cyc = cyc;
        busy_cnt = 1;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        while (!done && (cyc - acc_cyc) < 100) begin
            tick();
            if (!done && busy) busy_cnt++;
        end
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        start_op(o, av, bv);
        wait_done(tag);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        start   = 1'b1;
        op      = OP_MULTU;
        a       = 32'd9;
        b       = 32'd9;
        repeat (3) tick();
        start = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("hold_hi", 64'(hi), 64'hFFFF_FFFE);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        // Back-to-back: started in the done cycle of the previous op.
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);

        run_op("div_neg_a", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_neg_b", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        run_op("divu_zero", OP_DIVU, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF, 1'b1);
        repeat (4) tick();
        chk("dbz_held", 64'(div_by_zero), 64'd1);
        start_op(OP_DIVU, 32'd100, 32'd7);
        chk("dbz_cleared", 64'(div_by_zero), 64'd0);
        chk("hi_held_in_run", 64'(hi), 64'h64);
        wait_done("divu_after_dbz");
        chk("divu_after_dbz_lo", 64'(lo), 64'd14);

        run_op("div_zero_signed", OP_DIV, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

        // Start ignored while busy.
        tick();
        start_op(OP_MULTU, 32'd5, 32'd6);
        repeat (9) tick();
        op    = OP_DIVU;
        a     = 32'd77;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!done) busy_cnt += 10;
        wait_done("ignored_start");
        chk("ignored_start_hi", 64'(hi), 64'd0);
        chk("ignored_start_lo", 64'(lo), 64'd30);

        // Reset mid-run discards the operation.
        tick();
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        run_op("multu_after_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
